// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: active-high segment
// encodings {g,f,e,d,c,b,a} and the digit/slot dimensions.
package seg7_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned SLOT_W     = 2;

  typedef logic [SLOT_W-1:0] slot_t;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD nibble to active-high segment pattern; non-BCD
// nibbles (10..15) show a dash.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (nib)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// 4-digit multiplexed 7-segment driver with leading-zero blanking, decimal
// points and an anode guard interval. Optional SEG_DIMMING_EN adds PWM dimming.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned REFRESH_DIV    = 50000,
  parameter int unsigned GHOST_GUARD    = 4,
  parameter int unsigned ACTIVE_LOW_SEG = 1,
  parameter int unsigned ACTIVE_LOW_AN  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] thousands,
  input  logic [3:0] hundreds,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  input  logic [3:0] dp_in,
  input  logic       lzb,
`ifdef SEG_DIMMING_EN
  input  logic [3:0] brightness,
`endif
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       frame_done
);

  localparam int unsigned PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] GUARD_END  = PW'(GHOST_GUARD);
  localparam logic SEG_INV = (ACTIVE_LOW_SEG != 0);
  localparam logic AN_INV  = (ACTIVE_LOW_AN != 0);
  localparam logic [6:0] SEG_POL = {7{SEG_INV}};
  localparam logic [NUM_DIGITS-1:0] AN_POL = {NUM_DIGITS{AN_INV}};

  logic [PW-1:0]                 presc;
  slot_t                         slot;
  logic [NUM_DIGITS-1:0][3:0]    digit;
  logic [NUM_DIGITS-1:0]         dps;
`ifdef SEG_DIMMING_EN
  logic [3:0]                    pwm;
`endif

  logic [NUM_DIGITS-1:0] blank;
  logic [3:0]            cur_nib;
  logic [6:0]            dec_seg;
  logic [6:0]            seg_nxt;
  logic                  dp_nxt;
  logic [NUM_DIGITS-1:0] an_nxt;
  logic                  an_on;
  logic                  wrap;
  logic                  fd_nxt;

  seg7_decode u_decode (
    .nib (cur_nib),
    .seg (dec_seg)
  );

  always_comb begin
    cur_nib = digit[slot];
    wrap    = (presc == PRESC_LAST);
    fd_nxt  = wrap && (slot == slot_t'(NUM_DIGITS - 1));

    // Blanking ripples down from the leftmost digit; digit 0 always shows.
    blank    = '0;
    blank[3] = lzb && (digit[3] == 4'd0);
    blank[2] = blank[3] && (digit[2] == 4'd0);
    blank[1] = blank[2] && (digit[1] == 4'd0);

    an_on = (presc >= GUARD_END);
`ifdef SEG_DIMMING_EN
    an_on = an_on && (pwm < brightness);
`endif

    seg_nxt = (blank[slot] ? SEG_OFF : dec_seg) ^ SEG_POL;
    dp_nxt  = dps[slot] ^ SEG_INV;
    an_nxt  = (an_on ? (NUM_DIGITS'(1) << slot) : '0) ^ AN_POL;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc      <= '0;
      slot       <= '0;
      digit      <= '0;
      dps        <= '0;
`ifdef SEG_DIMMING_EN
      pwm        <= '0;
`endif
      seg        <= SEG_OFF ^ SEG_POL;
      dp         <= SEG_INV;
      an         <= AN_POL;
      frame_done <= 1'b0;
    end else begin
      if (load) begin
        digit <= {thousands, hundreds, tens, ones};
        dps   <= dp_in;
      end
      presc <= wrap ? '0 : presc + PW'(1);
      if (wrap) begin
        slot <= slot + slot_t'(1);
      end
`ifdef SEG_DIMMING_EN
      pwm <= pwm + 4'd1;
`endif
      seg        <= seg_nxt;
      dp         <= dp_nxt;
      an         <= an_nxt;
      frame_done <= fd_nxt;
    end
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Time-multiplexed driver for a 4-digit 7-segment display. It is fed by the 4-digit BCD converter, which supplies thousands, hundreds, tens and ones nibbles. The block latches those nibbles on a load strobe and scans one digit per refresh slot. It supports leading-zero blanking, decimal points and an anti-ghosting guard interval, and drives the board segment and anode pins directly.

Parameters:
REFRESH_DIV, 50000, clocks per digit slot; must be at least 2 and greater than GHOST_GUARD.
GHOST_GUARD, 4, clocks at the start of each slot with all anodes off.
ACTIVE_LOW_SEG, 1, 1 means seg and dp are active-low (common anode).
ACTIVE_LOW_AN, 1, 1 means the an outputs are active-low.

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active-low
load  in  1  capture strobe for the digit inputs and dp_in
thousands  in  4  BCD digit 3 (leftmost)
hundreds  in  4  BCD digit 2
tens  in  4  BCD digit 1
ones  in  4  BCD digit 0 (rightmost)
dp_in  in  4  decimal point per digit; bit i belongs to digit i
lzb  in  1  leading-zero blanking enable (live, not latched)
seg  out  7  segments {g,f,e,d,c,b,a}
dp  out  1  decimal point segment
an  out  4  digit anodes; an[i] selects digit i
frame_done  out  1  one-cycle pulse at the end of the digit-3 slot

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low; it is sampled only on the rising edge of clk.
- Reset state:
  - Shadow digits and shadow dp cleared to 0.
  - Prescaler at 0; slot index at 0.
  - an all inactive; seg all inactive; dp inactive; frame_done 0.
- Capture: on each rising edge with load=1, the shadow registers take the digit inputs and dp_in. If load is held high, capture happens every cycle. If load is low, the shadow holds.
- Prescaler: counts 0 to REFRESH_DIV-1, then wraps to 0.
  - On each wrap, the slot index advances 0→1→2→3→0.
  - Slot i drives digit i.
- Output timing:
  - All outputs are registered.
  - Outputs reflect the prescaler, slot and shadow values from the previous cycle, giving 1 clock of latency.
  - A load at edge N becomes visible at edge N+1 if the current slot is in its active phase.
- Guard interval:
  - While the prescaler is below GHOST_GUARD, an is all inactive.
  - seg and dp already carry the new digit during the guard interval.
  - Otherwise only an[slot] is active.
- Decode (active-high form, before polarity is applied):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Nibbles 10 to 15 are not valid BCD and display a dash (40).
- Leading-zero blanking (lzb=1):
  - Digit 3 is blanked if it is 0.
  - Digit 2 is blanked if digits 3 and 2 are both 0.
  - Digit 1 is blanked if digits 3, 2 and 1 are all 0.
  - Digit 0 is never blanked.
  - A blanked digit drives seg all inactive, but its anode still scans normally.
  - dp is not affected by blanking.
- Polarity: seg and dp are inverted when ACTIVE_LOW_SEG=1. an is inverted when ACTIVE_LOW_AN=1.
- frame_done: asserted for exactly 1 cycle, registered, on the cycle after the prescaler wraps out of slot 3.
- Reset mid-frame: the next edge with rst_n=0 forces the full reset state. Scanning restarts in slot 0 at prescaler 0 on the first edge after rst_n returns high.
- Simultaneous load and prescaler wrap: the new slot displays the newly captured value.

Optional Feature:
SEG_DIMMING_EN: when defined, the block adds input port brightness[3:0] and a free-running 4-bit PWM counter that is reset to 0.
- Within the active phase of a slot, an[slot] is active only while the PWM counter is less than brightness.
- brightness=0 keeps the display dark; brightness=15 gives 15/16 duty.
When not defined, there is no brightness port and the anode is active for the whole active phase.

Decomposition:
- Shared package/include seg7_pkg holds:
  - Segment encodings SEG_0 to SEG_9, SEG_DASH and SEG_OFF (active-high).
  - Slot index width and digit count (4).
- Sub-module seg7_decode: a combinational nibble-to-seg converter for 0 to 9 plus the dash. seg7_scan_driver instantiates it once, on the muxed digit.

Test Plan:
All scenarios use REFRESH_DIV=8, GHOST_GUARD=2, ACTIVE_LOW_SEG=1 and ACTIVE_LOW_AN=1.
1. Reset: rst_n=0 for 3 edges → an=4'b1111, seg=7'h7F, dp=1, frame_done=0. After release, an[0] goes low 3 edges later (2 guard cycles plus 1 of latency).
2. Load 1,2,3,4 with lzb=0 → slot 0 gives an=1110, seg=7'h19; slot 3 gives an=0111, seg=7'h79. frame_done pulses every 32 cycles.
3. Load 0,0,5,0 with lzb=1 → digits 3 and 2 show seg=7'h7F with their anodes still scanning; digit 1 shows 7'h12; digit 0 shows 7'h40. With lzb=0, digit 3 shows 7'h40.
4. Load hundreds=4'hC, dp_in=4'b0100 → slot 2 shows seg=7'h3F (dash) and dp=0.
5. Guard and change: load new digits mid-slot → seg updates 1 edge later. In every slot, an=1111 for the first 2 cycles.
6. Reset asserted during slot 2, then released → the shadow is 0, scanning resumes in slot 0, and no frame_done pulse appears for the aborted frame.
